// File: rtl/chamber_level_if.sv
// Request/gate inputs and level/status outputs of the chamber level controller.
interface chamber_level_if;
  logic       increase;
  logic       decrease;
  logic       gateR;
  logic       gateL;
  logic [3:0] level;
  logic       busy;
  logic       done;
  logic       reject;
  logic       abort;
  logic       leftGood;
  logic       rightGood;
  logic [6:0] hexOut;

  modport master (
    output increase, decrease, gateR, gateL,
    input  level, busy, done, reject, abort, leftGood, rightGood, hexOut
  );

  modport slave (
    input  increase, decrease, gateR, gateL,
    output level, busy, done, reject, abort, leftGood, rightGood, hexOut
  );
endinterface

// File: rtl/chamber_level_ctrl.sv
// Steps the modelled chamber level toward LEVEL_MAX or 0, one unit per STEP_CYCLES clocks, under gate interlock.
// Requests sampled only in IDLE and ignored while busy; status pulses are registered, one cycle after the causing edge.
module chamber_level_ctrl #(
  parameter int STEP_CYCLES = 4,
  parameter int LEVEL_MAX   = 5
) (
  input  logic           clk,
  input  logic           reset,
  chamber_level_if.slave bus
);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [3:0]    LVL_TOP  = 4'(LEVEL_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, done_q, reject_q, abort_q;
  logic          done_d, reject_d, abort_d;
  logic          gate_open, any_req, refuse;
  logic [3:0]    level_step;

  assign gate_open = bus.gateR | bus.gateL;
  assign any_req   = bus.increase | bus.decrease;
  assign refuse    = (bus.increase & bus.decrease) | gate_open
                   | (bus.increase & (level_q == LVL_TOP))
                   | (bus.decrease & (level_q == 4'd0));
  assign level_step = (state_q == FILL) ? level_q + 4'd1 : level_q - 4'd1;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    abort_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          if (refuse) begin
            reject_d = 1'b1;
          end else begin
            state_d = bus.increase ? FILL : DRAIN;
            cnt_d   = '0;
          end
        end
      end
      FILL, DRAIN: begin
        // An open gate wins over a level step landing on the same edge.
        if (gate_open) begin
          state_d = IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = level_step;
          if (((state_q == FILL) && (level_step == LVL_TOP)) ||
              ((state_q == DRAIN) && (level_step == 4'd0))) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= 4'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      reject_q <= reject_d;
      abort_q  <= abort_d;
    end
  end

  logic [6:0] hex_d;
  always_comb begin
    hex_d = 7'b1111111;
    unique case (level_q)
      4'd0: hex_d = 7'b1000000;
      4'd1: hex_d = 7'b1111001;
      4'd2: hex_d = 7'b0100100;
      4'd3: hex_d = 7'b0110000;
      4'd4: hex_d = 7'b0011001;
      4'd5: hex_d = 7'b0010010;
      4'd6: hex_d = 7'b0000010;
      4'd7: hex_d = 7'b1111000;
      4'd8: hex_d = 7'b0000000;
      4'd9: hex_d = 7'b0010000;
      default: hex_d = 7'b1111111;
    endcase
  end

  assign bus.level     = level_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reject    = reject_q;
  assign bus.abort     = abort_q;
  assign bus.leftGood  = (level_q == LVL_TOP) & ~busy_q;
  assign bus.rightGood = (level_q == 4'd0) & ~busy_q;
  assign bus.hexOut    = hex_d;
endmodule

// File: tb/tb_chamber_level_ctrl.sv
// Directed bench for chamber_level_ctrl: operation-level model checked every cycle plus literal spot checks.
module tb_chamber_level_ctrl;
  localparam int S   = 4;
  localparam int MAX = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  chamber_level_if bus();
  chamber_level_ctrl #(.STEP_CYCLES(S), .LEVEL_MAX(MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Inputs as seen by the DUT on each rising edge.
  logic c_rst = 1'b0, c_inc = 1'b0, c_dec = 1'b0, c_gr = 1'b0, c_gl = 1'b0;
  always @(posedge clk) begin
    c_rst <= reset;
    c_inc <= bus.increase;
    c_dec <= bus.decrease;
    c_gr  <= bus.gateR;
    c_gl  <= bus.gateL;
  end

  // Model tracks one operation: where it started, which way, how many steps, edges elapsed.
  bit m_valid = 0, m_act = 0, m_up = 0, m_done = 0, m_rej = 0, m_abort = 0;
  int m_lvl = 0, m_lvl0 = 0, m_n = 0, m_el = 0;

  always @(negedge clk) begin
    m_done = 0; m_rej = 0; m_abort = 0;
    if (c_rst) begin
      m_valid = 1; m_act = 0; m_lvl = 0;
    end else if (m_act) begin
      m_el++;
      if (m_el == m_n * S + 1) m_act = 0;
      else if (m_el < m_n * S && (c_gr || c_gl)) begin
        m_act = 0; m_abort = 1;
      end else if (m_el == m_n * S && (c_gr || c_gl)) begin
        m_act = 0; m_abort = 1;
      end else begin
        m_lvl = m_up ? m_lvl0 + m_el / S : m_lvl0 - m_el / S;
        if (m_el == m_n * S) m_done = 1;
      end
    end else if (c_inc || c_dec) begin
      if ((c_inc && c_dec) || c_gr || c_gl || (c_inc && m_lvl == MAX) || (c_dec && m_lvl == 0))
        m_rej = 1;
      else begin
        m_act = 1; m_el = 0; m_lvl0 = m_lvl; m_up = c_inc;
        m_n = c_inc ? MAX - m_lvl : m_lvl;
      end
    end
    if (m_valid) begin
      chk("level", int'(bus.level), m_lvl);
      chk("busy", int'(bus.busy), int'(m_act));
      chk("done", int'(bus.done), int'(m_done));
      chk("reject", int'(bus.reject), int'(m_rej));
      chk("abort", int'(bus.abort), int'(m_abort));
      chk("leftGood", int'(bus.leftGood), int'(m_lvl == MAX && !m_act));
      chk("rightGood", int'(bus.rightGood), int'(m_lvl == 0 && !m_act));
      chk("hexOut", int'(bus.hexOut), int'(seg[m_lvl]));
    end
  end

  // Request held for exactly one sampling edge; returns just after that edge.
  task automatic req(input bit i, input bit d, input bit r, input bit l);
    bus.increase = i; bus.decrease = d; bus.gateR = r; bus.gateL = l;
    @(negedge clk);
    bus.increase = 0; bus.decrease = 0; bus.gateR = 0; bus.gateL = 0;
  endtask

  initial begin
    bus.increase = 0; bus.decrease = 0; bus.gateR = 0; bus.gateL = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rightGood", int'(bus.rightGood), 1);
    chk("rst_leftGood", int'(bus.leftGood), 0);
    chk("rst_hex", int'(bus.hexOut), int'(7'b1000000));

    // Fill 0 -> 5
    req(1, 0, 0, 0);
    chk("fill_busy_e0", int'(bus.busy), 1);
    repeat (4) @(negedge clk);
    chk("fill_level_e4", int'(bus.level), 1);
    repeat (16) @(negedge clk);
    chk("fill_level_e20", int'(bus.level), 5);
    chk("fill_done_e20", int'(bus.done), 1);
    chk("fill_hex_e20", int'(bus.hexOut), int'(7'b0010010));
    @(negedge clk);
    chk("fill_busy_e21", int'(bus.busy), 0);
    chk("fill_leftGood_e21", int'(bus.leftGood), 1);
    chk("fill_done_e21", int'(bus.done), 0);
    repeat (2) @(negedge clk);

    // Reject at top, then drain 5 -> 0
    req(1, 0, 0, 0);
    chk("rej_top", int'(bus.reject), 1);
    chk("rej_top_level", int'(bus.level), 5);
    @(negedge clk);
    req(0, 1, 0, 0);
    repeat (4) @(negedge clk);
    chk("drain_level_e4", int'(bus.level), 4);
    repeat (16) @(negedge clk);
    chk("drain_level_e20", int'(bus.level), 0);
    chk("drain_done_e20", int'(bus.done), 1);
    @(negedge clk);
    chk("drain_rightGood_e21", int'(bus.rightGood), 1);

    // Remaining rejects at level 0
    req(0, 1, 0, 0);
    chk("rej_bottom", int'(bus.reject), 1);
    req(1, 1, 0, 0);
    chk("rej_both", int'(bus.reject), 1);
    req(1, 0, 1, 0);
    chk("rej_gateR", int'(bus.reject), 1);
    chk("rej_gateR_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("rej_one_cycle", int'(bus.reject), 0);

    // Abort: gateL opens at edge 9 of a fill
    req(1, 0, 0, 0);
    repeat (8) @(negedge clk);
    bus.gateL = 1;
    @(negedge clk);
    bus.gateL = 0;
    chk("abort_pulse", int'(bus.abort), 1);
    chk("abort_level", int'(bus.level), 2);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_goods", int'(bus.leftGood | bus.rightGood), 0);
    repeat (3) @(negedge clk);
    chk("abort_hold", int'(bus.level), 2);

    // Reset mid-fill at edge 10
    reset = 1; @(negedge clk); reset = 0;
    req(1, 0, 0, 0);
    repeat (9) @(negedge clk);
    chk("pre_rst_level", int'(bus.level), 2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_level", int'(bus.level), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_abort", int'(bus.abort), 0);
    repeat (6) @(negedge clk);
    chk("midrst_idle", int'(bus.level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
